// File: rtl/spi_pkg.sv
// Shared types and mode constants for the multi-chip-select SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles while enabled.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_c = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!en_i || tick_c) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_mc.sv
// SPI master with per-transfer mode and slave select, configurable width,
// divider and bit order; start/busy/done handshake on the system side.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_CS    = 4,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);

  spi_state_e        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;

  logic              tick_c;
  logic              div_en_c;
  logic              cs_ok_c;
  logic              leading_c;
  logic              last_c;
  logic [DATA_W-1:0] tx_shift_c;
  logic [DATA_W-1:0] rx_shift_c;

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
  endfunction

  assign div_en_c = (state_q != IDLE);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .en_i   (div_en_c),
    .tick_c (tick_c)
  );

  // Out-of-range slave indices are only possible when NUM_CS is not a power of two.
  if (NUM_CS == (1 << CS_W)) begin : g_cs_full
    assign cs_ok_c = 1'b1;
  end else begin : g_cs_part
    assign cs_ok_c = (32'(cs_sel) < NUM_CS);
  end

  assign tx_shift_c = (MSB_FIRST != 0) ? {tx_q[DATA_W-2:0], 1'b0} : {1'b0, tx_q[DATA_W-1:1]};
  assign rx_shift_c = (MSB_FIRST != 0) ? {rx_sh_q[DATA_W-2:0], miso} : {miso, rx_sh_q[DATA_W-1:1]};
  // edge_q counts completed edges, so the edge about to happen is odd when edge_q is even.
  assign leading_c  = ~edge_q[0];
  assign last_c     = (edge_q == EDGE_W'(2 * DATA_W - 1));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    edge_d    = edge_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;

    unique case (state_q)
      IDLE: begin
        if (start && cs_ok_c) begin
          state_d = LEAD;
          mode_d  = '{cpol: cpol, cpha: cpha};
          tx_d    = tx_data;
          rx_sh_d = '0;
          edge_d  = '0;
          busy_d  = 1'b1;
          cs_n_d  = ~(NUM_CS'(1) << cs_sel);
          sclk_d  = cpol;
          mosi_d  = cpha ? 1'b0 : first_bit(tx_data);
        end
      end
      LEAD: begin
        if (tick_c) state_d = XFER;
      end
      XFER: begin
        if (tick_c) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          if (!mode_q.cpha) begin
            if (leading_c) begin
              rx_sh_d = rx_shift_c;
            end else if (!last_c) begin
              tx_d   = tx_shift_c;
              mosi_d = first_bit(tx_shift_c);
            end
          end else begin
            if (leading_c) begin
              mosi_d = first_bit(tx_q);
              tx_d   = tx_shift_c;
            end else begin
              rx_sh_d = rx_shift_c;
            end
          end
          if (last_c) state_d = TRAIL;
        end
      end
      TRAIL: begin
        if (tick_c) begin
          state_d   = IDLE;
          cs_n_d    = '1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          mosi_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= SPI_MODE0;
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      edge_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      edge_q    <= edge_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: two parameterisations driven by a behavioural SPI slave.
module tb_spi_master_mc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: defaults. Instance 1: 16-bit, LSB first, divide-by-1, five slaves.
  logic       st0, cpol0, cpha0, busy0, done0, sclk0, mosi0, miso0;
  logic [1:0] cs0;
  logic [7:0] tx0, rx0;
  logic [3:0] csn0;
  logic        st1, cpol1, cpha1, busy1, done1, sclk1, mosi1, miso1;
  logic [2:0]  cs1;
  logic [15:0] tx1, rx1;
  logic [4:0]  csn1;

  spi_master_mc #(.DATA_W(8), .NUM_CS(4), .CLK_DIV(4), .MSB_FIRST(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(st0), .cpol(cpol0), .cpha(cpha0), .cs_sel(cs0),
    .tx_data(tx0), .rx_data(rx0), .busy(busy0), .done(done0), .sclk(sclk0),
    .mosi(mosi0), .miso(miso0), .cs_n(csn0));

  spi_master_mc #(.DATA_W(16), .NUM_CS(5), .CLK_DIV(1), .MSB_FIRST(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(st1), .cpol(cpol1), .cpha(cpha1), .cs_sel(cs1),
    .tx_data(tx1), .rx_data(rx1), .busy(busy1), .done(done1), .sclk(sclk1),
    .mosi(mosi1), .miso(miso1), .cs_n(csn1));

  int   n_tests = 0;
  int   n_fail  = 0;
  int   sel     = 0;
  bit   loop    = 1'b0;
  logic s_miso  = 1'b0;
  logic [15:0] last_rx [2];

  assign miso0 = loop ? mosi0 : s_miso;
  assign miso1 = loop ? mosi1 : s_miso;

  logic        m_sclk, m_mosi, m_busy, m_done;
  logic [15:0] m_rx;
  logic [4:0]  m_csn;
  always_comb begin
    if (sel == 0) begin
      m_sclk = sclk0; m_mosi = mosi0; m_busy = busy0; m_done = done0;
      m_rx = {8'h00, rx0}; m_csn = {1'b1, csn0};
    end else begin
      m_sclk = sclk1; m_mosi = mosi1; m_busy = busy1; m_done = done1;
      m_rx = rx1; m_csn = csn1;
    end
  end

  function automatic int wid(input int d);  return (d == 0) ? 8 : 16; endfunction
  function automatic int div(input int d);  return (d == 0) ? 4 : 1;  endfunction
  function automatic int ncs(input int d);  return (d == 0) ? 4 : 5;  endfunction
  function automatic bit msbf(input int d); return (d == 0);          endfunction

  // Bit i of a frame in transmission order.
  function automatic logic bit_at(input logic [15:0] w, input int i, input int d);
    if (msbf(d)) return w[4'(wid(d) - 1 - i)];
    return w[4'(i)];
  endfunction

  function automatic logic [4:0] csn_exp(input int d, input int cs);
    logic [4:0] v;
    v = 5'h1F;
    v[3'(cs)] = 1'b0;
    if (d == 0) v[4] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic st, input logic pol, input logic pha,
                       input int cs, input logic [15:0] w);
    if (d == 0) begin
      st0 = st; cpol0 = pol; cpha0 = pha; cs0 = 2'(cs); tx0 = w[7:0];
    end else begin
      st1 = st; cpol1 = pol; cpha1 = pha; cs1 = 3'(cs); tx1 = w;
    end
  endtask

  // One frame: accept, act as an SPI slave on observed sclk edges, check result.
  // chained: accept edge is the next posedge (start already high from a previous frame).
  // hold: leave start high and return in the done cycle.
  task automatic run_frame(input int d, input logic [15:0] txw_i, input logic [15:0] slw_i,
                           input logic pol, input logic pha, input int cs, input bit lb,
                           input bit chained, input bit hold, input int poke_k);
    int          w, edges, lat, csn_bad, rx_bad, idx;
    logic [15:0] mask, txw, slw, cap, exp_rx;
    logic        prev;
    bit          lead;
    w = wid(d); edges = 0; lat = -1; csn_bad = 0; rx_bad = 0; cap = '0; prev = pol;
    mask   = (w == 16) ? 16'hFFFF : 16'h00FF;
    txw    = txw_i & mask;
    slw    = slw_i & mask;
    exp_rx = lb ? txw : slw;
    sel = d; loop = lb;
    if (!chained) @(negedge clk);
    drive(d, 1'b1, pol, pha, cs, txw);
    @(posedge clk);
    for (int k = 0; k < 400 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("accept_busy", 32'(m_busy), 32'd1);
        check("accept_sclk", 32'(m_sclk), 32'(pol));
        prev = m_sclk;
        if (!hold) drive(d, 1'b0, ~pol, ~pha, (cs + 1) % ncs(d), 16'($urandom));
        if (!pha) s_miso = bit_at(slw, 0, d);
      end
      if (poke_k >= 0 && k == poke_k) drive(d, 1'b1, ~pol, pha, cs, 16'($urandom));
      if (poke_k >= 0 && k == poke_k + 1) drive(d, 1'b0, pol, pha, cs, 16'($urandom));
      if (m_sclk !== prev) begin
        edges++;
        prev = m_sclk;
        lead = (edges % 2) == 1;
        if (lead == (pha == 1'b0)) begin
          idx = (edges - 1) / 2;
          if (idx < w) begin
            if (msbf(d)) cap[4'(w - 1 - idx)] = m_mosi;
            else         cap[4'(idx)] = m_mosi;
          end
        end else begin
          idx = edges / 2;
          if (idx < w) s_miso = bit_at(slw, idx, d);
        end
      end
      if (m_done === 1'b1) begin
        lat = k;
      end else begin
        if (m_csn !== csn_exp(d, cs)) csn_bad++;
        if (m_rx !== last_rx[d]) rx_bad++;
      end
    end
    // Cycles counted from the accept cycle itself to the done cycle.
    check("latency", 32'(lat + 1), 32'(1 + div(d) * (2 * w + 2)));
    check("sclk_edges", 32'(edges), 32'(2 * w));
    check("mosi_frame", 32'(cap), 32'(txw));
    check("rx_data", 32'(m_rx), 32'(exp_rx));
    check("done_busy", 32'(m_busy), 32'd0);
    check("done_csn", 32'(m_csn), 32'h1F);
    check("done_sclk", 32'(m_sclk), 32'(pol));
    check("done_mosi", 32'(m_mosi), 32'd0);
    check("csn_during", 32'(csn_bad), 32'd0);
    check("rx_hold", 32'(rx_bad), 32'd0);
    last_rx[d] = exp_rx;
    if (!hold) begin
      @(negedge clk);
      check("done_pulse", 32'(m_done), 32'd0);
    end
  endtask

  task automatic invalid_cs();
    int dn;
    dn = 0;
    sel = 1;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 1'b0, 5, 16'hBEEF);
    repeat (3) @(negedge clk);
    check("bad_cs5_busy", 32'(busy1), 32'd0);
    check("bad_cs5_csn", 32'(csn1), 32'h1F);
    drive(1, 1'b1, 1'b1, 1'b1, 7, 16'h1111);
    repeat (3) @(negedge clk);
    check("bad_cs7_busy", 32'(busy1), 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 0, 16'h0000);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done1 === 1'b1) dn++;
    end
    check("bad_cs_done", 32'(dn), 32'd0);
    check("bad_cs_rx", 32'(rx1), 32'(last_rx[1]));
  endtask

  task automatic reset_mid_frame();
    int dn;
    dn = 0;
    sel = 0; loop = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, 1, 16'h005A);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 1'b0, 1, 16'h005A);
    repeat (29) @(negedge clk);
    check("pre_rst_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_csn", 32'(csn0), 32'hF);
    check("rst_sclk", 32'(sclk0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_rx", 32'(rx0), 32'd0);
    last_rx[0] = '0;
    last_rx[1] = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done0 === 1'b1) dn++;
    end
    check("rst_no_done", 32'(dn), 32'd0);
  endtask

  initial begin
    int d, cs;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 0, 16'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 0, 16'h0);
    last_rx[0] = '0;
    last_rx[1] = '0;
    repeat (3) @(negedge clk);
    check("rst_rx0", 32'(rx0), 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_done0", 32'(done0), 32'd0);
    check("rst_sclk0", 32'(sclk0), 32'd0);
    check("rst_mosi0", 32'(mosi0), 32'd0);
    check("rst_csn0", 32'(csn0), 32'hF);
    check("rst_csn1", 32'(csn1), 32'h1F);
    rst = 1'b0;

    run_frame(0, 16'h00A5, 16'h003C, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
    run_frame(0, 16'h0081, 16'h0000, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0, -1);
    check("idle_sclk_hi", 32'(sclk0), 32'd1);
    run_frame(1, 16'h1234, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, -1);
    run_frame(0, 16'($urandom), 16'($urandom), 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 10);
    invalid_cs();
    reset_mid_frame();
    run_frame(0, 16'h00C3, 16'h0096, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, -1);
    run_frame(0, 16'h0055, 16'h00F0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1, -1);
    run_frame(0, 16'h00AA, 16'h000F, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0, -1);

    for (int i = 0; i < 12; i++) begin
      d  = int'($urandom_range(0, 1));
      cs = int'($urandom_range(0, ncs(d) - 1));
      run_frame(d, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), cs,
                1'($urandom), 1'b0, 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
